systolic_matmul_engine: RTL and testbench
=========================================

# systolic_matmul_engine

Parametrised output-stationary matrix-multiply engine for the NPU datapath, computing C = A × B for SIZE×SIZE tiles over a run-time inner dimension. It accepts one k-slice per beat (column k of A, row k of B) through a valid/ready handshake and skews operands internally so callers never pre-skew. It also supports signed or unsigned operands, accumulation across runs, and a start/busy/done control handshake. It sits between the operand buffers and the result writeback.

## Interface
- SIZE, 4, array dimension (rows = columns), ≥2
- DATA_W, 8, operand width
- ACC_W, 32, accumulator/result width, must be ≥ 2*DATA_W
- K_MAX, 255, largest accepted k_len; KW = $clog2(K_MAX+1)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a run; sampled only in IDLE or DONE
- k_len  in  KW  inner-dimension length, latched on accepted start
- signed_mode  in  1  1 = two's-complement operands, latched on start
- acc_en  in  1  1 = keep previous results and accumulate, latched on start
- in_valid  in  1  beat present on in_west/in_north
- in_ready  out  1  engine accepts a beat this cycle
- in_west  in  [SIZE][DATA_W]  A[i][k] for row i
- in_north  in  [SIZE][DATA_W]  B[k][j] for column j
- busy  out  1  high in LOAD and DRAIN
- done  out  1  one-cycle pulse: results final
- result  out  [SIZE][SIZE][ACC_W]  C[i][j], held from done until next accepted start

## Operation
- States: IDLE, LOAD, DRAIN, DONE.
- IDLE/DONE + start: latch k_len, signed_mode, acc_en. If acc_en=0, clear all accumulators on that edge. Go to LOAD, or to DONE if k_len=0.
- LOAD: in_ready=1 while beats accepted < k_len. A beat transfers when in_valid & in_ready. After beat k_len-1 transfers, go to DRAIN.
- Array advances every cycle. A cycle in LOAD without a transfer injects zeros into row 0 / column 0 skew inputs (bubble). Bubbles never change results.
- Skew: row i of A delayed i cycles, column j of B delayed j cycles. PE(i,j) multiplies, adds into its accumulator, and forwards a east and b south one register per hop.
- DRAIN: exactly 2*SIZE-1 cycles; all products of the last beat must be accumulated by its end. Then go to DONE.
- DONE: done=1 for one cycle, then IDLE. A start here is accepted exactly as in IDLE.
- start in LOAD/DRAIN is ignored. in_valid outside LOAD is ignored.
- Arithmetic:
  - Product is 2*DATA_W wide, sign-extended (signed_mode=1) or zero-extended to ACC_W.
  - Accumulation wraps modulo 2^ACC_W; no saturation, no overflow flag.
- rst: return to IDLE. in_ready=0, busy=0, done=0, all result and skew registers = 0. Applies mid-run, and any partial run is discarded.

## Timing
- Cycle 0: start accepted (edge ending cycle 0). Cycle 1: state LOAD, busy=1, in_ready=1.
- With no stalls, beats transfer in cycles 1..k_len. DRAIN occupies cycles k_len+1..k_len+2*SIZE-1. done=1 in cycle k_len+2*SIZE.
- Each stall cycle delays done by exactly one cycle.
- k_len=0: done=1 in cycle 1, busy never asserts.
- in_ready depends only on state and beat count, never on in_valid.
- result changes only while busy, or on the clearing edge of an accepted start with acc_en=0.

## Test plan
- SIZE=4, A=B=I, k_len=4, unsigned, in_valid held high -> result = identity, done pulses exactly in cycle 12, busy high cycles 1–11.
- A,B all 8'hFF, k_len=4: unsigned -> every C[i][j]=260100; signed_mode=1 -> every C[i][j]=4.
- Random 4×4 A,B with in_valid low every other cycle -> result equals software model, done delayed by the 3 stall cycles to cycle 15, no beat lost or duplicated.
- Run A=B=I, then a second run with acc_en=1 and the same data -> diagonal = 2, off-diagonal = 0. A third run with acc_en=0 -> diagonal = 1.
- rst asserted in DRAIN cycle 7 -> next cycle all outputs 0, no done pulse. A following identity run completes normally.
- k_len=0 start -> done in cycle 1, result all 0. start pulsed during LOAD -> ignored, run completes with original k_len.

Source files
------------

// File: rtl/systolic_matmul_engine.sv
// Purpose: output-stationary SIZExSIZE systolic matrix multiply, C = A x B over a run-time inner dimension.
// Latency: start accepted in cycle 0, done pulses in cycle k_len + 2*SIZE (+1 per stall cycle); k_len=0 -> cycle 1.
// Backpressure: in_ready depends only on state/beat count; an idle LOAD cycle injects a zero bubble.
//
// Ports: clk/rst (sync, active-high); start/k_len/signed_mode/acc_en control (latched on accepted start);
//        in_valid/in_ready/in_west/in_north carry one k-slice per beat (A column k, B row k);
//        busy (LOAD/DRAIN), done (one-cycle pulse), result[i][j] = C[i][j] held until next accepted start.
module systolic_matmul_engine #(
    parameter int SIZE   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int K_MAX  = 255,
    parameter int KW     = $clog2(K_MAX + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [KW-1:0]                         k_len,
    input  logic                                  signed_mode,
    input  logic                                  acc_en,
    input  logic                                  in_valid,
    output logic                                  in_ready,
    input  logic [SIZE-1:0][DATA_W-1:0]           in_west,
    input  logic [SIZE-1:0][DATA_W-1:0]           in_north,
    output logic                                  busy,
    output logic                                  done,
    output logic [SIZE-1:0][SIZE-1:0][ACC_W-1:0]  result
);

    localparam int DRAIN_CYC = 2 * SIZE - 1;
    localparam int DCW       = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

    state_t          state;
    logic [KW-1:0]   k_q;
    logic [KW-1:0]   beat_cnt;
    logic [DCW-1:0]  drain_cnt;
    logic            signed_q;
    logic            xfer;
    logic            start_ok;
    logic            acc_clear;

    // in_ready is only ever high in LOAD, so this also filters in_valid outside LOAD.
    assign xfer      = in_valid & in_ready;
    assign start_ok  = start & ((state == IDLE) | (state == DONE));
    assign acc_clear = start_ok & ~acc_en;

    // Control FSM; in_ready/busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            k_q       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            signed_q  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (start) begin
                        k_q      <= k_len;
                        signed_q <= signed_mode;
                        beat_cnt <= '0;
                        if (k_len == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            busy     <= 1'b1;
                            in_ready <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (beat_cnt == k_q - 1'b1) begin
                            state     <= DRAIN;
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                        end
                    end
                end
                DRAIN: begin
                    // The last beat reaches PE(SIZE-1,SIZE-1) 2*SIZE-2 cycles after entering the array.
                    if (drain_cnt == DCW'(DRAIN_CYC - 1)) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Input skew: row i of A and column i of B see i extra register stages.
    logic [SIZE-1:0][DATA_W-1:0] a_edge;
    logic [SIZE-1:0][DATA_W-1:0] b_edge;

    for (genvar i = 0; i < SIZE; i++) begin : g_skew
        logic [DATA_W-1:0] a_sk [i+1];
        logic [DATA_W-1:0] b_sk [i+1];

        always_ff @(posedge clk) begin
            if (rst) begin
                for (int d = 0; d <= i; d++) begin
                    a_sk[d] <= '0;
                    b_sk[d] <= '0;
                end
            end else begin
                // Non-transfer cycles inject zeros so bubbles contribute nothing.
                a_sk[0] <= xfer ? in_west[i]  : '0;
                b_sk[0] <= xfer ? in_north[i] : '0;
                for (int d = 1; d <= i; d++) begin
                    a_sk[d] <= a_sk[d-1];
                    b_sk[d] <= b_sk[d-1];
                end
            end
        end

        assign a_edge[i] = a_sk[i];
        assign b_edge[i] = b_sk[i];
    end

    // PE operand network: a travels east, b travels south, one register per hop.
    logic [DATA_W-1:0] a_in  [SIZE][SIZE];
    logic [DATA_W-1:0] b_in  [SIZE][SIZE];
    logic [DATA_W-1:0] a_reg [SIZE][SIZE-1];
    logic [DATA_W-1:0] b_reg [SIZE-1][SIZE];

    always_comb begin
        for (int i = 0; i < SIZE; i++) begin
            a_in[i][0] = a_edge[i];
            for (int j = 1; j < SIZE; j++) begin
                a_in[i][j] = a_reg[i][j-1];
            end
        end
        for (int j = 0; j < SIZE; j++) begin
            b_in[0][j] = b_edge[j];
            for (int i = 1; i < SIZE; i++) begin
                b_in[i][j] = b_reg[i-1][j];
            end
        end
    end

    function automatic logic [ACC_W-1:0] mul_ext(input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b,
                                                 input logic              sgn);
        logic signed [2*DATA_W-1:0] ps;
        logic        [2*DATA_W-1:0] pu;
        ps = $signed({{DATA_W{a[DATA_W-1]}}, a}) * $signed({{DATA_W{b[DATA_W-1]}}, b});
        pu = {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
        return sgn ? ACC_W'(ps) : ACC_W'(pu);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE - 1; j++) begin
                    a_reg[i][j] <= '0;
                    b_reg[j][i] <= '0;
                end
            end
            result <= '0;
        end else begin
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE - 1; j++) begin
                    a_reg[i][j] <= a_in[i][j];
                    b_reg[j][i] <= b_in[j][i];
                end
            end
            // Accumulators only move while busy; wrap modulo 2^ACC_W.
            if (acc_clear) begin
                result <= '0;
            end else if (busy) begin
                for (int i = 0; i < SIZE; i++) begin
                    for (int j = 0; j < SIZE; j++) begin
                        result[i][j] <= result[i][j] + mul_ext(a_in[i][j], b_in[i][j], signed_q);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
module tb_systolic_matmul_engine;

    logic                     clk;
    logic                     rst;
    logic                     start;
    logic [7:0]               k_len;
    logic                     signed_mode;
    logic                     acc_en;
    logic                     in_valid;
    logic                     in_ready;
    logic [3:0][7:0]          in_west;
    logic [3:0][7:0]          in_north;
    logic                     busy;
    logic                     done;
    logic [3:0][3:0][31:0]    result;

    systolic_matmul_engine #(.SIZE(4), .DATA_W(8), .ACC_W(32), .K_MAX(255)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .k_len       (k_len),
        .signed_mode (signed_mode),
        .acc_en      (acc_en),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_west     (in_west),
        .in_north    (in_north),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  ma [4][4];
    logic [7:0]  mb [4][4];
    logic [31:0] exp_c [4][4];

    int done_cyc, done_cnt, busy_first, busy_last, busy_cnt, beats;

    task automatic set_identity();
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = (i == j) ? 8'd1 : 8'd0;
                mb[i][j] = (i == j) ? 8'd1 : 8'd0;
            end
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = v;
                mb[i][j] = v;
            end
    endtask

    task automatic model(input int k, input bit sgn);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                int s;
                s = 0;
                for (int kk = 0; kk < k; kk++) begin
                    int av, bv;
                    av = sgn ? int'($signed(ma[i][kk])) : int'(ma[i][kk]);
                    bv = sgn ? int'($signed(mb[kk][j])) : int'(mb[kk][j]);
                    s += av * bv;
                end
                exp_c[i][j] = s;
            end
    endtask

    task automatic drive_beat(input int bi, input int k);
        for (int r = 0; r < 4; r++) begin
            in_west[r]  = (in_valid && bi < k) ? ma[r][bi] : 8'hA5;
            in_north[r] = (in_valid && bi < k) ? mb[bi][r] : 8'h5A;
        end
    endtask

    // Runs one job from start (cycle 0) until two cycles after done, or a cycle budget.
    task automatic run_job(input int k, input bit sgn, input bit acc, input bit stall, input bit mid_start);
        int bi;
        @(posedge clk); #1;
        start = 1'b1; k_len = 8'(k); signed_mode = sgn; acc_en = acc; in_valid = 1'b0;
        bi = 0; done_cyc = -1; done_cnt = 0; busy_first = -1; busy_last = -1; busy_cnt = 0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            start       = (mid_start && cyc == 2);
            k_len       = 8'd1;
            signed_mode = ~sgn;
            acc_en      = ~acc;
            in_valid    = stall ? (cyc % 2 == 1) : 1'b1;
            drive_beat(bi, k);
            @(negedge clk);
            if (in_valid && in_ready) bi++;
            if (busy) begin
                if (busy_first < 0) busy_first = cyc;
                busy_last = cyc;
                busy_cnt++;
            end
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 2) break;
        end
        @(posedge clk); #1;
        in_valid = 1'b0; start = 1'b0;
        beats = bi;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
    endtask

    task automatic test_identity();
        set_identity();
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (done_cyc != 12) begin errors++; $display("FAIL ident_done_cycle got %0d want 12", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL ident_done_pulses got %0d want 1", done_cnt); end
        checks++; if (busy_first != 1 || busy_last != 11 || busy_cnt != 11) begin
            errors++; $display("FAIL ident_busy got %0d..%0d (%0d) want 1..11 (11)", busy_first, busy_last, busy_cnt); end
        checks++; if (beats != 4) begin errors++; $display("FAIL ident_beats got %0d want 4", beats); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (result[i][j] !== ((i == j) ? 32'd1 : 32'd0)) begin
                    errors++; $display("FAIL ident_c%0d%0d got %0d want %0d", i, j, result[i][j], (i == j) ? 1 : 0); end
            end
    endtask

    task automatic test_all_ff();
        set_all(8'hFF);
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (result[i][j] !== 32'd260100) begin
                    errors++; $display("FAIL ff_unsigned_c%0d%0d got %0d want 260100", i, j, result[i][j]); end
            end
        run_job(4, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (result[i][j] !== 32'd4) begin
                    errors++; $display("FAIL ff_signed_c%0d%0d got %0d want 4", i, j, result[i][j]); end
            end
    endtask

    task automatic test_stall();
        logic [7:0] av [16];
        logic [7:0] bv [16];
        av = '{8'd200, 8'd1, 8'd4, 8'd1, 8'd5, 8'd9, 8'd2, 8'd6, 8'd5, 8'd3, 8'd5, 8'd8, 8'd9, 8'd7, 8'd9, 8'd3};
        bv = '{8'd2, 8'd7, 8'd1, 8'd8, 8'd2, 8'd8, 8'd1, 8'd8, 8'd2, 8'd8, 8'd4, 8'd5, 8'd9, 8'd0, 8'd4, 8'd250};
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                ma[i][j] = av[i*4+j];
                mb[i][j] = bv[i*4+j];
            end
        model(4, 1'b0);
        run_job(4, 1'b0, 1'b0, 1'b1, 1'b0);
        checks++; if (done_cyc != 15) begin errors++; $display("FAIL stall_done_cycle got %0d want 15", done_cyc); end
        checks++; if (beats != 4) begin errors++; $display("FAIL stall_beats got %0d want 4", beats); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (result[i][j] !== exp_c[i][j]) begin
                    errors++; $display("FAIL stall_c%0d%0d got %0d want %0d", i, j, result[i][j], exp_c[i][j]); end
            end
    endtask

    task automatic test_accumulate();
        set_identity();
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
        run_job(4, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (result[i][j] !== ((i == j) ? 32'd2 : 32'd0)) begin
                    errors++; $display("FAIL accum_c%0d%0d got %0d want %0d", i, j, result[i][j], (i == j) ? 2 : 0); end
            end
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (result[i][j] !== ((i == j) ? 32'd1 : 32'd0)) begin
                    errors++; $display("FAIL reclear_c%0d%0d got %0d want %0d", i, j, result[i][j], (i == j) ? 1 : 0); end
            end
    endtask

    task automatic test_reset_mid_run();
        int dpulses;
        set_identity();
        @(posedge clk); #1;
        start = 1'b1; k_len = 8'd4; signed_mode = 1'b0; acc_en = 1'b0; in_valid = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b1;
            drive_beat(cyc - 1, 4);
            if (cyc == 7) rst = 1'b1;
        end
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b want 0", in_ready); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %b want 0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL midrst_result got %h want 0", result); end
        dpulses = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done) dpulses++;
        end
        checks++; if (dpulses != 0) begin errors++; $display("FAIL midrst_no_done got %0d pulses want 0", dpulses); end
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (done_cyc != 12) begin errors++; $display("FAIL midrst_rerun_done got %0d want 12", done_cyc); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (result[i][i] !== 32'd1) begin errors++; $display("FAIL midrst_rerun_c%0d%0d got %0d want 1", i, i, result[i][i]); end
        end
    endtask

    task automatic test_k_zero();
        run_job(0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (done_cyc != 1) begin errors++; $display("FAIL kzero_done_cycle got %0d want 1", done_cyc); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL kzero_done_pulses got %0d want 1", done_cnt); end
        checks++; if (busy_cnt != 0) begin errors++; $display("FAIL kzero_busy got %0d cycles want 0", busy_cnt); end
        checks++; if (result !== '0) begin errors++; $display("FAIL kzero_result got %h want 0", result); end
    endtask

    task automatic test_start_in_load();
        set_identity();
        run_job(4, 1'b0, 1'b0, 1'b0, 1'b1);
        checks++; if (done_cyc != 12) begin errors++; $display("FAIL midstart_done got %0d want 12", done_cyc); end
        checks++; if (beats != 4) begin errors++; $display("FAIL midstart_beats got %0d want 4", beats); end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                checks++;
                if (result[i][j] !== ((i == j) ? 32'd1 : 32'd0)) begin
                    errors++; $display("FAIL midstart_c%0d%0d got %0d want %0d", i, j, result[i][j], (i == j) ? 1 : 0); end
            end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_len = '0; signed_mode = 1'b0; acc_en = 1'b0;
        in_valid = 1'b0; in_west = '0; in_north = '0;
        test_reset();
        test_identity();
        test_all_ff();
        test_stall();
        test_accumulate();
        test_reset_mid_run();
        test_k_zero();
        test_start_in_load();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
